// File: rtl/divider_seq_if.sv
// Handshake bundle for divider_seq: operand request channel plus result response channel.
interface divider_seq_if #(parameter int D_SIZE = 8);
  logic              in_valid;
  logic              in_ready;
  logic [D_SIZE-1:0] dividend;
  logic [D_SIZE-1:0] divisor;
  logic              out_valid;
  logic              out_ready;
  logic [D_SIZE-1:0] quotient;
  logic [D_SIZE-1:0] remainder;
  logic              div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divider_seq.sv
// Iterative restoring divider, one quotient bit per clock, fixed D_SIZE-cycle latency.
// Define DIVIDER_SIGNED_EN for two's-complement truncating division.
module divider_seq #(
  parameter int D_SIZE = 8
) (
  input  logic        clk,
  input  logic        rst,
  divider_seq_if.slave bus
);
  localparam int CW = $clog2(D_SIZE);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [D_SIZE-1:0] dvd, dsr, quo, rem;
  logic [CW-1:0]     cnt;
  logic              in_ready_q, out_valid_q, dbz_q;
  logic [D_SIZE-1:0] quotient_q, remainder_q;

  logic [D_SIZE:0]   shifted, diff;
  logic              fits;
  logic [D_SIZE-1:0] rem_nxt, quo_nxt, quo_fin, rem_fin, a_mag, b_mag;

`ifdef DIVIDER_SIGNED_EN
  logic neg_q, neg_r;
`endif

  always_comb begin
    shifted = {rem, dvd[D_SIZE-1]};
    diff    = shifted - {1'b0, dsr};
    fits    = (shifted >= {1'b0, dsr});
    rem_nxt = fits ? diff[D_SIZE-1:0] : shifted[D_SIZE-1:0];
    quo_nxt = {quo[D_SIZE-2:0], fits};
`ifdef DIVIDER_SIGNED_EN
    // Divide by zero already yields all-ones magnitude; keep it unnegated.
    quo_fin = (dsr == '0) ? '1 : (neg_q ? -quo_nxt : quo_nxt);
    rem_fin = neg_r ? -rem_nxt : rem_nxt;
    a_mag   = bus.dividend[D_SIZE-1] ? -bus.dividend : bus.dividend;
    b_mag   = bus.divisor[D_SIZE-1]  ? -bus.divisor  : bus.divisor;
`else
    quo_fin = quo_nxt;
    rem_fin = rem_nxt;
    a_mag   = bus.dividend;
    b_mag   = bus.divisor;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      dvd         <= '0;
      dsr         <= '0;
      quo         <= '0;
      rem         <= '0;
      cnt         <= '0;
`ifdef DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          dvd        <= a_mag;
          dsr        <= b_mag;
          rem        <= '0;
          quo        <= '0;
          cnt        <= '0;
          in_ready_q <= 1'b0;
          state      <= BUSY;
`ifdef DIVIDER_SIGNED_EN
          neg_q      <= bus.dividend[D_SIZE-1] ^ bus.divisor[D_SIZE-1];
          neg_r      <= bus.dividend[D_SIZE-1];
`endif
        end
        BUSY: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          dvd <= dvd << 1;
          cnt <= cnt + 1'b1;
          // Final iteration: results (with any sign fix-up) land directly in the output regs.
          if (cnt == CW'(D_SIZE - 1)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            quotient_q  <= quo_fin;
            remainder_q <= rem_fin;
            dbz_q       <= (dsr == '0);
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_divider_seq.sv
// Scoreboard bench for divider_seq: expected results queued at accept, checked at out_valid.
module tb_divider_seq;
  localparam int D = 8;

  typedef struct packed {
    logic [D-1:0] q;
    logic [D-1:0] r;
    logic         z;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  divider_seq_if #(.D_SIZE(D)) bus();
  divider_seq #(.D_SIZE(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   errors = 0;
  int   checks = 0;
  res_t sb[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t model(input logic [D-1:0] a, input logic [D-1:0] b);
    res_t m;
    int   sa, sbv, qi, ri;
    sa = 0; sbv = 0; qi = 0; ri = 0;
    if (b == '0) begin
      m.q = '1; m.r = a; m.z = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      qi  = sa / sbv;
      ri  = sa % sbv;
      m.q = qi[D-1:0];
      m.r = ri[D-1:0];
`else
      m.q = a / b;
      m.r = a % b;
`endif
      m.z = 1'b0;
    end
    return m;
  endfunction

  task automatic issue(input logic [D-1:0] a, input logic [D-1:0] b, input bit push);
    int n = 0;
    while (!bus.in_ready && n < 50) begin step(); n++; end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL issue_ready: in_ready=%b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1; bus.dividend = a; bus.divisor = b;
    if (push) sb.push_back(model(a, b));
    step();
    bus.in_valid = 1'b0;
    bus.dividend = D'($urandom);
    bus.divisor  = D'($urandom);
  endtask

  // Waits for out_valid, checks latency and the scoreboard entry; does not consume the result.
  task automatic collect(input string name, output res_t got);
    int   k = 0;
    res_t exp;
    while (!bus.out_valid && k < 4*D) begin step(); k++; end
    checks++;
    if (k !== D) begin
      errors++; $display("FAIL %s_latency: got %0d cycles required %0d", name, k, D);
    end
    got.q = bus.quotient; got.r = bus.remainder; got.z = bus.div_by_zero;
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL %s_sb_empty: no expected entry queued", name);
    end else begin
      exp = sb.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s_result: q=%h r=%h z=%b required q=%h r=%h z=%b",
                 name, got.q, got.r, got.z, exp.q, exp.r, exp.z);
      end
    end
  endtask

  task automatic run_op(input string name, input logic [D-1:0] a, input logic [D-1:0] b,
                        output res_t got);
    bus.out_ready = 1'b1;
    issue(a, b, 1'b1);
    collect(name, got);
`ifndef DIVIDER_SIGNED_EN
    if (b != '0) begin
      checks++;
      if ((int'(got.q) * int'(b) + int'(got.r)) != int'(a) || got.r >= b) begin
        errors++;
        $display("FAIL %s_invariant: %h/%h gave q=%h r=%h", name, a, b, got.q, got.r);
      end
    end
`endif
    step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: in_ready=%b out_valid=%b required 1 0", name, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.div_by_zero} !== 3'b100 ||
        bus.quotient !== '0 || bus.remainder !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b z=%b q=%h r=%h required 1 0 0 00 00",
               bus.in_ready, bus.out_valid, bus.div_by_zero, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_basic();
    res_t g;
    run_op("basic", 8'd100, 8'd7, g);
`ifndef DIVIDER_SIGNED_EN
    checks++;
    if (g.q !== 8'd14 || g.r !== 8'd2 || g.z !== 1'b0) begin
      errors++; $display("FAIL basic_const: q=%0d r=%0d z=%b required 14 2 0", g.q, g.r, g.z);
    end
`endif
  endtask

  task automatic test_div_zero();
    res_t g;
    run_op("dbz", 8'd5, 8'd0, g);
    checks++;
    if (g.q !== 8'hFF || g.r !== 8'd5 || g.z !== 1'b1) begin
      errors++; $display("FAIL dbz_const: q=%h r=%h z=%b required ff 05 1", g.q, g.r, g.z);
    end
  endtask

  task automatic test_backpressure();
    res_t g;
    bus.out_ready = 1'b0;
    issue(8'd200, 8'd9, 1'b1);
    collect("bp", g);
`ifndef DIVIDER_SIGNED_EN
    checks++;
    if (g.q !== 8'd22 || g.r !== 8'd2) begin
      errors++; $display("FAIL bp_const: q=%0d r=%0d required 22 2", g.q, g.r);
    end
`endif
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0); bus.dividend = 8'd1; bus.divisor = 8'd1;
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.quotient !== g.q || bus.remainder !== g.r) begin
        errors++;
        $display("FAIL bp_hold%0d: vld=%b rdy=%b q=%h r=%h required 1 0 %h %h",
                 i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, g.q, g.r);
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: rdy=%b vld=%b required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_midop();
    res_t g;
    bus.out_ready = 1'b1;
    issue(8'd255, 8'd3, 1'b0);
    step(); step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.quotient !== '0 || bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: vld=%b rdy=%b q=%h r=%h z=%b required 0 1 00 00 0",
               bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL midrst_ghost: out_valid=%b required 0 at cycle %0d", bus.out_valid, i);
      end
    end
    run_op("midrst_next", 8'd9, 8'd4, g);
    checks++;
    if (g.q !== 8'd2 || g.r !== 8'd1) begin
      errors++; $display("FAIL midrst_next_const: q=%0d r=%0d required 2 1", g.q, g.r);
    end
  endtask

  task automatic test_random();
    res_t g;
    logic [D-1:0] a, b;
    run_op("f9_2", 8'hF9, 8'h02, g);
    checks++;
`ifdef DIVIDER_SIGNED_EN
    if (g.q !== 8'hFD || g.r !== 8'hFF) begin
      errors++; $display("FAIL f9_2_const: q=%h r=%h required fd ff", g.q, g.r);
    end
`else
    if (g.q !== 8'd124 || g.r !== 8'd1) begin
      errors++; $display("FAIL f9_2_const: q=%0d r=%0d required 124 1", g.q, g.r);
    end
`endif
    for (int i = 0; i < 1000; i++) begin
      a = D'($urandom);
      b = ($urandom_range(0, 15) == 0) ? '0 : D'($urandom);
      run_op("rand", a, b, g);
    end
  endtask

  task automatic test_back_to_back();
    int gap = 0;
    res_t g;
    bus.out_ready = 1'b1;
    issue(8'd77, 8'd5, 1'b1);
    collect("b2b_a", g);
    bus.in_valid = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd6;
    sb.push_back(model(8'd50, 8'd6));
    gap = D + 1;
    while (!bus.in_ready && gap < 3*D) begin step(); gap++; end
    step(); bus.in_valid = 1'b0;
    checks++;
    if (gap !== D + 2) begin
      errors++; $display("FAIL b2b_spacing: accept spacing %0d required %0d", gap, D + 2);
    end
    collect("b2b_b", g);
    step();
  endtask

`ifdef DIVIDER_SIGNED_EN
  task automatic test_signed();
    res_t g;
    run_op("s_m128_m1", 8'h80, 8'hFF, g);
    checks++;
    if (g.q !== 8'h80 || g.r !== 8'h00 || g.z !== 1'b0) begin
      errors++; $display("FAIL s_m128_m1_const: q=%h r=%h z=%b required 80 00 0", g.q, g.r, g.z);
    end
    run_op("s_dbz_neg", 8'hFB, 8'h00, g);
    checks++;
    if (g.q !== 8'hFF || g.r !== 8'hFB || g.z !== 1'b1) begin
      errors++; $display("FAIL s_dbz_neg_const: q=%h r=%h z=%b required ff fb 1", g.q, g.r, g.z);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.dividend = '0;   bus.divisor = '0;
    test_reset();
    test_basic();
    test_div_zero();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
`ifdef DIVIDER_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
